dm_responder: RTL and testbench

//   Data-memory responder on the far side of the pipeline's load/store path.

---
 rtl/dm_responder.sv | 185 ++++++++++++++++++
 tb/tb_dm_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: one access at a time, fixed wait states, then a
// one-cycle response carrying extended load data or an error flag.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH + 2;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;

  logic          lat_wr;
  logic [1:0]    lat_size;
  logic          lat_sext;
  logic          lat_err;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;

  logic [31:0]   mem [DEPTH];

  logic          req_err;
  logic          acc_wr;
  logic [1:0]    acc_size;
  logic          acc_sext;
  logic          acc_err;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;

  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   old_word;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [31:0]   new_word;
  logic          enter_resp;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)                           req_err = 1'b1;
    if (req_size == 2'd1 && req_addr[0])            req_err = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'd0)  req_err = 1'b1;
    if ((req_addr[31:2] >> ADDR_WIDTH) != 30'd0)    req_err = 1'b1;
  end

  // With zero wait states the access completes on the accept edge itself,
  // so the commit path must see the live request rather than the latches.
  always_comb begin
    if (state == IDLE) begin
      acc_wr    = req_wr;
      acc_size  = req_size;
      acc_sext  = req_sext;
      acc_err   = req_err;
      acc_addr  = req_addr[AW-1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_wr    = lat_wr;
      acc_size  = lat_size;
      acc_sext  = lat_sext;
      acc_err   = lat_err;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP);
  assign widx       = acc_addr[AW-1:2];
  assign lane       = acc_addr[1:0];
  assign old_word   = mem[widx];
  assign shifted    = old_word >> {lane, 3'b000};

  always_comb begin
    case (acc_size)
      2'd0:    ld_data = acc_sext ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'h000000, shifted[7:0]};
      2'd1:    ld_data = acc_sext ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'h0000, shifted[15:0]};
      default: ld_data = old_word;
    endcase
  end

  // Replicating the right-aligned data puts it on every lane; the byte
  // enables then pick the lanes that are actually written.
  always_comb begin
    case (acc_size)
      2'd0: begin
        be   = 4'b0001 << lane;
        wrep = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        be   = 4'b0011 << {lane[1], 1'b0};
        wrep = {2{acc_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = acc_wdata;
      end
    endcase
    for (int unsigned k = 0; k < 4; k++) begin
      new_word[8*k +: 8] = be[k] ? wrep[8*k +: 8] : old_word[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_wr     <= 1'b0;
      lat_size   <= '0;
      lat_sext   <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_size  <= req_size;
            lat_sext  <= req_sext;
            lat_err   <= req_err;
            lat_addr  <= req_addr[AW-1:0];
            lat_wdata <= req_wdata;
            cnt       <= WAIT_LOAD;
          end
        end
        WAIT:    cnt <= cnt - 4'd1;
        default: ;
      endcase
      resp_rdata <= (enter_resp && !acc_err && !acc_wr) ? ld_data : '0;
      resp_err   <= enter_resp && acc_err;
      if (enter_resp && acc_wr && !acc_err) begin
        mem[widx] <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: byte-addressed reference memory checked every cycle,
// plus directed accesses with literal expected results.
module tb_dm_responder;

  localparam int unsigned WAITC = 2;
  localparam int unsigned NWORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, response scheduled by time.
  logic [7:0]  bm [NWORDS*4];
  bit          mvalid = 1'b0;
  bit          pend = 1'b0;
  int unsigned cyc = 0;
  int unsigned resp_at = 0;
  logic [31:0] e_rdata;
  logic        e_err;

  always @(negedge clk) begin
    bit          ev;
    int unsigned n;
    logic [31:0] a;
    logic [31:0] v;
    if (mvalid) begin
      ev = pend && (cyc == resp_at);
      chk("m_ready", 32'(req_ready), 32'(!pend));
      chk("m_busy", 32'(busy), 32'(pend));
      chk("m_valid", 32'(resp_valid), 32'(ev));
      chk("m_rdata", resp_rdata, ev ? e_rdata : 32'h0);
      chk("m_err", 32'(resp_err), 32'(ev && e_err));
    end
    if (reset) begin
      for (int i = 0; i < NWORDS*4; i++) bm[i] = 8'h00;
      pend = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (pend && cyc == resp_at) begin
        pend = 1'b0;
      end else if (!pend && req_valid) begin
        a = req_addr;
        n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        e_err = (req_size == 2'd3) || (a % n != 0) || (a / 4 >= NWORDS);
        e_rdata = 32'h0;
        if (!e_err) begin
          if (req_wr) begin
            for (int k = 0; k < int'(n); k++) bm[a + k] = req_wdata[8*k +: 8];
          end else begin
            v = 32'h0;
            for (int k = 0; k < int'(n); k++) v = v | (32'(bm[a + k]) << (8*k));
            if (req_sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            e_rdata = v;
          end
        end
        pend = 1'b1;
        resp_at = cyc + WAITC + 1;
      end
    end
    cyc++;
  end

  task automatic issue(input logic wr, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: request at 0x%08h never accepted", addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    bit ok;
    bit got;
    int lat;
    issue(wr, size, sext, addr, wdata, ok);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
        chk({name, "_rdata"}, resp_rdata, exp_rd);
        chk({name, "_err"}, 32'(resp_err), 32'(exp_err));
      end
    end
    chk({name, "_resp_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'd3);
  endtask

  initial begin
    bit ok;
    int na;
    int prev;
    int nresp;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);

    do_req("t1_st_w",   1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("t1_ld_w",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("t2_st_b",   1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 32'h0, 1'b0);
    do_req("t2_ld_bs",  1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("t2_ld_bu",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0);
    do_req("t2_ld_w",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    do_req("t3_st_h",   1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 32'h0, 1'b0);
    do_req("t3_ld_w",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    do_req("t3_ld_hs",  1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    do_req("t3_ld_hp",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0);
    do_req("t3_mis_w",  1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
    do_req("t3_mis_sw", 1'b1, 2'd2, 1'b0, 32'h12, 32'hAAAAAAAA, 32'h0, 1'b1);
    do_req("t3_unchg",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    do_req("t4_range",  1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1);
    do_req("t4_size3",  1'b1, 2'd3, 1'b0, 32'h0, 32'h55555555, 32'h0, 1'b1);
    do_req("t4_nowr",   1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    do_req("t4_top",    1'b1, 2'd2, 1'b0, 32'h3FFC, 32'h0BADF00D, 32'h0, 1'b0);
    do_req("t4_top_rd", 1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 32'h0BADF00D, 1'b0);

    // Held request: accepts must be four cycles apart.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h10;
    na = 0;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin
        if (na > 0) chk("t5_spacing", 32'(i - prev), 32'd4);
        prev = i;
        na++;
      end
    end
    chk("t5_accepts", 32'(na), 32'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during WAIT discards the store.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFFFFFF, ok);
    @(negedge clk);
    chk("t6_busy_wait", 32'(busy), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    nresp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("t6_no_resp", 32'(nresp), 32'd0);
    do_req("t6_ld",     1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0);
    do_req("t6_ld_old", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
